// File: rtl/ppu_oaram_writer_if.sv
// Bus between the tile-buffer drain engine and its controller / buffer / OARAM.
interface ppu_oaram_writer_if #(
  parameter int unsigned RAM_WIDTH   = 10,
  parameter int unsigned BANK_COUNT  = 32,
  parameter int unsigned TILE_SIZE   = 128,
  parameter int unsigned INDEX_WIDTH = 4
);
  logic                          start;
  logic [1:0]                    bitwidth;
  logic [$clog2(BANK_COUNT)-1:0] buffer_bank_read;
  logic [$clog2(TILE_SIZE)-1:0]  buffer_bank_entry;
  logic signed [7:0]             buffer_data_read;
  logic [24:0]                   oaram_value;
  logic [INDEX_WIDTH-1:0]        oaram_indices_value;
  logic [RAM_WIDTH-2:0]          oaram_address;
  logic                          oaram_write_enable;
  logic                          busy;
  logic                          done;
  logic [RAM_WIDTH-1:0]          entry_count;
  logic                          overflow;

  modport master (
    output start, bitwidth, buffer_data_read,
    input  buffer_bank_read, buffer_bank_entry, oaram_value, oaram_indices_value,
           oaram_address, oaram_write_enable, busy, done, entry_count, overflow
  );

  modport slave (
    input  start, bitwidth, buffer_data_read,
    output buffer_bank_read, buffer_bank_entry, oaram_value, oaram_indices_value,
           oaram_address, oaram_write_enable, busy, done, entry_count, overflow
  );
endinterface

// File: rtl/ppu_oaram_writer.sv
// Drains the accumulation tile buffer into OARAM as ReLU/clamped values with
// zero-run indices, skipping zeros and suppressing trailing zeros.
module ppu_oaram_writer #(
  parameter int unsigned RAM_WIDTH   = 10,
  parameter int unsigned BANK_COUNT  = 32,
  parameter int unsigned TILE_SIZE   = 128,
  parameter int unsigned INDEX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ppu_oaram_writer_if.slave    bus
);
  localparam int unsigned BW = $clog2(BANK_COUNT);
  localparam int unsigned EW = $clog2(TILE_SIZE);
  localparam int unsigned AW = RAM_WIDTH - 1;
  localparam logic [INDEX_WIDTH-1:0] MAXRUN     = '1;
  localparam logic [AW-1:0]          ADDR_LAST  = '1;
  localparam logic [BW-1:0]          BANK_LAST  = BW'(BANK_COUNT - 1);
  localparam logic [EW-1:0]          ENTRY_LAST = EW'(TILE_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [BW-1:0]          r_bank;
  logic [EW-1:0]          r_entry;
  logic [1:0]             r_bitwidth;
  logic                   r_sample_vld;
  logic [INDEX_WIDTH-1:0] r_run;
  logic [AW-1:0]          r_wr_addr;
  logic                   r_full;
  logic [6:0]             r_val;
  logic [INDEX_WIDTH-1:0] r_idx;
  logic [AW-1:0]          r_oaram_address;
  logic                   r_we;
  logic                   r_busy;
  logic                   r_done;
  logic [RAM_WIDTH-1:0]   r_entry_count;
  logic                   r_overflow;

  logic                   w_start_ok;
  logic                   w_last_rd;
  logic [6:0]             w_pos;
  logic [6:0]             w_max;
  logic [6:0]             w_v;
  logic                   w_need_wr;

  assign w_start_ok = (r_state == S_IDLE) && bus.start;
  assign w_last_rd  = (r_state == S_READ) && (r_bank == BANK_LAST) && (r_entry == ENTRY_LAST);

  // ReLU, precision clamp and the decision whether this sample produces an entry
  always_comb begin
    w_pos = bus.buffer_data_read[7] ? 7'd0 : bus.buffer_data_read[6:0];
    case (r_bitwidth)
      2'b00:   w_max = 7'd127;
      2'b01:   w_max = 7'd15;
      2'b10:   w_max = 7'd3;
      default: w_max = 7'd1;
    endcase
    w_v       = (w_pos > w_max) ? w_max : w_pos;
    w_need_wr = r_sample_vld && ((w_v != 7'd0) || (r_run == MAXRUN));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state; DRAIN covers the last sample slot and the done slot
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_READ;
      S_READ:  if (w_last_rd) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_done)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read address sequencing, run encoding and OARAM write registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank          <= '0;
      r_entry         <= '0;
      r_bitwidth      <= '0;
      r_sample_vld    <= 1'b0;
      r_run           <= '0;
      r_wr_addr       <= '0;
      r_full          <= 1'b0;
      r_val           <= '0;
      r_idx           <= '0;
      r_oaram_address <= '0;
      r_we            <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_entry_count   <= '0;
      r_overflow      <= 1'b0;
    end else begin
      r_we         <= 1'b0;
      r_done       <= 1'b0;
      r_sample_vld <= (r_state == S_READ);

      if (w_start_ok) begin
        r_bitwidth      <= bus.bitwidth;
        r_bank          <= '0;
        r_entry         <= '0;
        r_run           <= '0;
        r_wr_addr       <= '0;
        r_full          <= 1'b0;
        r_oaram_address <= '0;
        r_entry_count   <= '0;
        r_overflow      <= 1'b0;
        r_busy          <= 1'b1;
      end

      if (r_state == S_READ) begin
        if (r_entry == ENTRY_LAST) begin
          r_entry <= '0;
          r_bank  <= (r_bank == BANK_LAST) ? '0 : r_bank + BW'(1);
        end else begin
          r_entry <= r_entry + EW'(1);
        end
      end

      if (r_sample_vld) begin
        if (w_need_wr) begin
          r_run <= '0;
          if (r_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_we            <= 1'b1;
            r_val           <= w_v;
            r_idx           <= r_run;
            r_oaram_address <= r_wr_addr;
            r_entry_count   <= r_entry_count + RAM_WIDTH'(1);
            if (r_wr_addr == ADDR_LAST) r_full <= 1'b1;
            else                        r_wr_addr <= r_wr_addr + AW'(1);
          end
        end else begin
          r_run <= r_run + INDEX_WIDTH'(1);
        end
      end

      if ((r_state == S_DRAIN) && r_sample_vld) r_done <= 1'b1;
      if ((r_state == S_DRAIN) && r_done)       r_busy <= 1'b0;
    end
  end

  assign bus.buffer_bank_read    = r_bank;
  assign bus.buffer_bank_entry   = r_entry;
  assign bus.oaram_value         = 25'(r_val);
  assign bus.oaram_indices_value = r_idx;
  assign bus.oaram_address       = r_oaram_address;
  assign bus.oaram_write_enable  = r_we;
  assign bus.busy                = r_busy;
  assign bus.done                = r_done;
  assign bus.entry_count         = r_entry_count;
  assign bus.overflow            = r_overflow;
endmodule

// File: tb/tb_ppu_oaram_writer.sv
// Scoreboard bench for ppu_oaram_writer across three parameter sets.
module tb_ppu_oaram_writer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ppu_oaram_writer_if #(.RAM_WIDTH(10), .BANK_COUNT(2), .TILE_SIZE(4),  .INDEX_WIDTH(4)) if_a ();
  ppu_oaram_writer_if #(.RAM_WIDTH(10), .BANK_COUNT(2), .TILE_SIZE(16), .INDEX_WIDTH(4)) if_b ();
  ppu_oaram_writer_if #(.RAM_WIDTH(3),  .BANK_COUNT(2), .TILE_SIZE(4),  .INDEX_WIDTH(4)) if_c ();

  ppu_oaram_writer #(.RAM_WIDTH(10), .BANK_COUNT(2), .TILE_SIZE(4),  .INDEX_WIDTH(4)) u_a (.clk(clk), .reset(rst), .bus(if_a));
  ppu_oaram_writer #(.RAM_WIDTH(10), .BANK_COUNT(2), .TILE_SIZE(16), .INDEX_WIDTH(4)) u_b (.clk(clk), .reset(rst), .bus(if_b));
  ppu_oaram_writer #(.RAM_WIDTH(3),  .BANK_COUNT(2), .TILE_SIZE(4),  .INDEX_WIDTH(4)) u_c (.clk(clk), .reset(rst), .bus(if_c));

  logic       start_r [3];
  logic [1:0] bw_r    [3];
  logic       done_w  [3];
  logic       busy_w  [3];
  logic       ovf_w   [3];
  int         ec_w    [3];
  int         mem     [32];

  assign if_a.start = start_r[0];  assign if_a.bitwidth = bw_r[0];
  assign if_b.start = start_r[1];  assign if_b.bitwidth = bw_r[1];
  assign if_c.start = start_r[2];  assign if_c.bitwidth = bw_r[2];
  assign done_w[0] = if_a.done;  assign busy_w[0] = if_a.busy;  assign ovf_w[0] = if_a.overflow;
  assign done_w[1] = if_b.done;  assign busy_w[1] = if_b.busy;  assign ovf_w[1] = if_b.overflow;
  assign done_w[2] = if_c.done;  assign busy_w[2] = if_c.busy;  assign ovf_w[2] = if_c.overflow;
  assign ec_w[0] = 32'(if_a.entry_count);
  assign ec_w[1] = 32'(if_b.entry_count);
  assign ec_w[2] = 32'(if_c.entry_count);

  // Tile buffer model: data valid one cycle after the address
  always @(posedge clk) begin
    if_a.buffer_data_read <= 8'(mem[int'(if_a.buffer_bank_read) * 4  + int'(if_a.buffer_bank_entry)]);
    if_b.buffer_data_read <= 8'(mem[int'(if_b.buffer_bank_read) * 16 + int'(if_b.buffer_bank_entry)]);
    if_c.buffer_data_read <= 8'(mem[int'(if_c.buffer_bank_read) * 4  + int'(if_c.buffer_bank_entry)]);
  end

  typedef struct {int addr; int val; int idx;} wr_t;
  wr_t q_exp [$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic see_write(input string tag, input int addr, input int val, input int idx);
    wr_t e;
    if (q_exp.size() == 0) begin
      check({tag, " unexpected write addr"}, addr, -1);
      return;
    end
    e = q_exp.pop_front();
    check({tag, " wr addr"}, addr, e.addr);
    check({tag, " wr value"}, val, e.val);
    check({tag, " wr index"}, idx, e.idx);
  endtask

  always @(negedge clk) if (if_a.oaram_write_enable)
    see_write("a", int'(if_a.oaram_address), int'(if_a.oaram_value), int'(if_a.oaram_indices_value));
  always @(negedge clk) if (if_b.oaram_write_enable)
    see_write("b", int'(if_b.oaram_address), int'(if_b.oaram_value), int'(if_b.oaram_indices_value));
  always @(negedge clk) if (if_c.oaram_write_enable)
    see_write("c", int'(if_c.oaram_address), int'(if_c.oaram_value), int'(if_c.oaram_indices_value));

  function automatic int clamp_max(input logic [1:0] bw);
    case (bw)
      2'b00:   return 127;
      2'b01:   return 15;
      2'b10:   return 3;
      default: return 1;
    endcase
  endfunction

  // Reference encoder: pushes the expected OARAM writes for mem[0..n-1]
  function automatic void model(input int n, input int m, input int cap, output int cnt, output bit ovf);
    int run = 0;
    cnt = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      int d = mem[i];
      int v = (d < 0) ? 0 : ((d > m) ? m : d);
      if (v != 0 || run == 15) begin
        if (cnt < cap) begin
          q_exp.push_back('{cnt, v, run});
          cnt++;
        end else begin
          ovf = 1'b1;
        end
        run = 0;
      end else begin
        run++;
      end
    end
  endfunction

  task automatic chk_zero_a(input string tag);
    check({tag, " bank"},  int'(if_a.buffer_bank_read), 0);
    check({tag, " entry"}, int'(if_a.buffer_bank_entry), 0);
    check({tag, " value"}, int'(if_a.oaram_value), 0);
    check({tag, " index"}, int'(if_a.oaram_indices_value), 0);
    check({tag, " addr"},  int'(if_a.oaram_address), 0);
    check({tag, " we"},    int'(if_a.oaram_write_enable), 0);
    check({tag, " busy"},  int'(if_a.busy), 0);
    check({tag, " done"},  int'(if_a.done), 0);
    check({tag, " count"}, int'(if_a.entry_count), 0);
    check({tag, " ovf"},   int'(if_a.overflow), 0);
  endtask

  task automatic load8(input int v [8]);
    foreach (mem[i]) mem[i] = 0;
    for (int i = 0; i < 8; i++) mem[i] = v[i];
  endtask

  // One drain on instance s; optional stray starts and a reset at cycle rst_cyc
  task automatic drain(input string tag, input int s, input logic [1:0] bw, input int n,
                       input int cap, input bit poke, input int rst_cyc);
    int   cnt;
    bit   ovf;
    int   done_cyc = -1;
    int   ndone = 0;
    logic busy_h [64];
    q_exp.delete();
    model(n, clamp_max(bw), cap, cnt, ovf);
    if (rst_cyc >= 0) while (q_exp.size() > rst_cyc - 1) void'(q_exp.pop_back());
    @(negedge clk);
    bw_r[s]    = bw;
    start_r[s] = 1'b1;
    @(negedge clk);
    start_r[s] = 1'b0;
    for (int c = 0; c <= n + 5; c++) begin
      busy_h[c] = busy_w[s];
      if (done_w[s]) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (rst_cyc >= 0 && c == rst_cyc + 1) begin
        chk_zero_a({tag, " post-reset"});
        rst = 1'b0;
      end
      start_r[s] = poke && (c == 3 || c == n + 1);
      if (c == rst_cyc) rst = 1'b1;
      @(negedge clk);
    end
    start_r[s] = 1'b0;
    if (rst_cyc < 0) begin
      check({tag, " done cycle"}, done_cyc, n + 1);
      check({tag, " done pulses"}, ndone, 1);
      check({tag, " busy c0"}, int'(busy_h[0]), 1);
      check({tag, " busy c4"}, int'(busy_h[4]), 1);
      check({tag, " busy done"}, int'(busy_h[n + 1]), 1);
      check({tag, " busy after"}, int'(busy_h[n + 2]), 0);
      check({tag, " busy late"}, int'(busy_h[n + 4]), 0);
      check({tag, " entry_count"}, ec_w[s], cnt);
      check({tag, " overflow"}, int'(ovf_w[s]), int'(ovf));
    end else begin
      check({tag, " done pulses"}, ndone, 0);
      check({tag, " busy late"}, int'(busy_h[n + 4]), 0);
    end
    check({tag, " writes left"}, q_exp.size(), 0);
  endtask

  initial begin
    int s1 [8] = '{5, 0, 0, -3, 0, 9, 0, 0};
    int s2 [8] = '{100, 2, -1, 7, 0, 0, 0, 1};
    int s3 [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int s4 [8] = '{10, 20, 30, 40, 50, 60, 70, 80};
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0;
      bw_r[i]    = 2'b00;
    end
    foreach (mem[i]) mem[i] = 0;
    repeat (3) @(negedge clk);
    chk_zero_a("reset");
    rst = 1'b0;

    load8(s1);
    drain("sparse", 0, 2'b00, 8, 512, 1'b0, -1);
    load8(s2);
    drain("clamp3", 0, 2'b10, 8, 512, 1'b0, -1);
    load8(s2);
    drain("clamp15", 0, 2'b01, 8, 512, 1'b0, -1);
    load8(s2);
    drain("clamp1", 0, 2'b11, 8, 512, 1'b0, -1);

    foreach (mem[i]) mem[i] = 0;
    mem[16] = 4;
    drain("maxrun", 1, 2'b00, 32, 512, 1'b0, -1);

    load8(s3);
    drain("full", 2, 2'b00, 8, 4, 1'b0, -1);
    load8(s3);
    drain("full again", 2, 2'b01, 8, 4, 1'b0, -1);

    load8(s1);
    drain("stray start", 0, 2'b00, 8, 512, 1'b1, -1);

    load8(s4);
    drain("abort", 0, 2'b00, 8, 512, 1'b0, 4);

    for (int k = 0; k < 4; k++) begin
      foreach (mem[i]) mem[i] = 0;
      for (int i = 0; i < 8; i++)
        mem[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) - 128 : 0;
      drain("random", 0, 2'($urandom_range(0, 3)), 8, 512, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
